// File: rtl/ds_host_pkg.sv
// ds_host_pkg: machine status encoding, sequencer FSM states and default
// frame geometry shared by ds_host_sequencer and its testbench.
package ds_host_pkg;

    // Encoding of the machine status port
    typedef enum logic [1:0] {
        MST_IDLE = 2'd0,
        MST_LOAD = 2'd1,
        MST_RUN  = 2'd2,
        MST_READ = 2'd3
    } mstat_t;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_READ,
        S_DONE
    } state_t;

    // Default frame geometry: 128x128 load, 64x64 result at 0x4000
    localparam int unsigned DEF_LOAD_LEN    = 16384;
    localparam int unsigned DEF_RESULT_BASE = 32'h0000_4000;
    localparam int unsigned DEF_RESULT_LEN  = 4096;

endpackage

// File: rtl/ds_rd_skid.sv
// ds_rd_skid: 2-entry FIFO that absorbs the one-cycle data-memory read
// latency while the result stream is back-pressured.
module ds_rd_skid #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    // Storage write, pointer advance and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ds_host_sequencer.sv
// ds_host_sequencer: loads a raw frame from the host into machine data
// memory, runs the machine until end_process, then streams the result back
// out with backpressure. Optional running checksum of the result stream is
// built only when DS_HOST_CHECKSUM_EN is defined.
module ds_host_sequencer
    import ds_host_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 16,
    parameter int unsigned          DATA_W      = 8,
    parameter int unsigned          LOAD_LEN    = DEF_LOAD_LEN,
    parameter logic [ADDR_W-1:0]    RESULT_BASE = ADDR_W'(DEF_RESULT_BASE),
    parameter int unsigned          RESULT_LEN  = DEF_RESULT_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        m_status,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_end_process,
    input  logic [DATA_W-1:0] m_data_out,
    output logic [15:0]       checksum
);

    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] LOAD_LAST = (ADDR_W+1)'(LOAD_LEN - 1);
    localparam logic [ADDR_W:0] RD_LEN    = (ADDR_W+1)'(RESULT_LEN);
    localparam logic [ADDR_W:0] RD_LAST   = (ADDR_W+1)'(RESULT_LEN - 1);

    state_t            r_state;
    mstat_t            r_m_status;
    logic [DATA_W-1:0] r_m_data;
    logic [ADDR_W-1:0] r_m_addr;
    logic              r_in_ready;
    logic              r_done;
    logic              r_cap;
    logic [ADDR_W:0]   r_load_cnt;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W:0]   r_out_cnt;

    logic              w_in_acc;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [1:0]        w_skid_cnt;
    logic              w_pop;
    logic [2:0]        w_room;
    logic              w_issue;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_in_acc  = in_valid && r_in_ready;
    assign w_pop     = w_skid_valid && out_ready;
    assign w_rd_addr = RESULT_BASE + r_rd_cnt[ADDR_W-1:0];

    // Read issue is decided in the same cycle it is presented; the pop
    // happening this cycle frees a slot, which keeps 1 byte/cycle with only
    // two entries of buffering.
    assign w_room  = {1'b0, w_skid_cnt} + {2'b00, r_cap} - {2'b00, w_pop};
    assign w_issue = (r_state == S_READ) && (r_rd_cnt < RD_LEN) && (w_room < 3'd2);

    ds_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_cap),
        .i_data  (m_data_out),
        .i_pop   (w_pop),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_count (w_skid_cnt)
    );

    // Frame sequencing FSM with registered machine-side and host-side controls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_m_status <= MST_IDLE;
            r_m_data   <= '0;
            r_m_addr   <= '0;
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_cap      <= 1'b0;
            r_load_cnt <= '0;
            r_rd_cnt   <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_cap  <= w_issue;
            case (r_state)
                S_IDLE: begin
                    r_m_status <= MST_IDLE;
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                        r_load_cnt <= '0;
                        r_rd_cnt   <= '0;
                        r_out_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_in_acc) begin
                        r_m_status <= MST_LOAD;
                        r_m_data   <= in_data;
                        r_m_addr   <= r_load_cnt[ADDR_W-1:0];
                        r_load_cnt <= r_load_cnt + CNT_ONE;
                        if (r_load_cnt == LOAD_LAST) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_RUN;
                        end
                    end else begin
                        r_m_status <= MST_IDLE;
                    end
                end
                S_RUN: begin
                    if (m_end_process) begin
                        r_state    <= S_READ;
                        r_m_status <= MST_IDLE;
                    end else begin
                        r_m_status <= MST_RUN;
                    end
                end
                S_READ: begin
                    r_m_status <= MST_IDLE;
                    if (w_issue) begin
                        r_rd_cnt <= r_rd_cnt + CNT_ONE;
                    end
                    if (w_pop) begin
                        r_out_cnt <= r_out_cnt + CNT_ONE;
                        if (r_out_cnt == RD_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_m_status <= MST_IDLE;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // During READ the status/address reflect the live issue decision
    assign m_status  = (r_state == S_READ) ? (w_issue ? MST_READ : MST_IDLE) : r_m_status;
    assign m_addr    = w_issue ? w_rd_addr : r_m_addr;
    assign m_data    = r_m_data;
    assign in_ready  = r_in_ready;
    assign out_valid = w_skid_valid;
    assign out_data  = w_skid_valid ? w_skid_data : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

`ifdef DS_HOST_CHECKSUM_EN
    logic [15:0] r_checksum;

    // Running sum of accepted result bytes, cleared as a new frame starts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + 16'(w_skid_data);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ds_host_sequencer.sv
// Directed testbench for ds_host_sequencer with a small data-memory model.
module tb_ds_host_sequencer;

    localparam int unsigned LL = 16;
    localparam int unsigned RL = 4;

`ifdef DS_HOST_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [1:0]  m_status;
    logic [7:0]  m_data;
    logic [15:0] m_addr;
    logic        m_end_process;
    logic [7:0]  m_data_out = 8'h00;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    ds_host_sequencer #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .LOAD_LEN    (LL),
        .RESULT_BASE (16'h0008),
        .RESULT_LEN  (RL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .m_status      (m_status),
        .m_data        (m_data),
        .m_addr        (m_addr),
        .m_end_process (m_end_process),
        .m_data_out    (m_data_out),
        .checksum      (checksum)
    );

    // Data memory model plus write log and stream bookkeeping
    logic [7:0]  mem      [0:255];
    logic [15:0] log_addr [0:255];
    logic [7:0]  log_data [0:255];
    int wr_cnt = 0;
    int rd_iss = 0;
    int rd_acc = 0;
    int done_cnt = 0;
    int max_out = 0;

    always @(posedge clk) begin
        m_data_out <= mem[m_addr[7:0]];
        if (m_status == 2'd1) begin
            mem[m_addr[7:0]] <= m_data;
            log_addr[wr_cnt & 255] = m_addr;
            log_data[wr_cnt & 255] = m_data;
            wr_cnt++;
        end
        if (m_status == 2'd3) rd_iss++;
        if (out_valid && out_ready) rd_acc++;
        if (done) done_cnt++;
        if (rd_iss - rd_acc > max_out) max_out = rd_iss - rd_acc;
    end

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] img [0:15];
    logic [7:0] exp_out [0:3];
    int first_acc;
    int last_acc;
    int wr_base;
    int done_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int gap, input int n);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < n && cyc < 400) begin
            in_valid = (cyc % gap == 0);
            in_data  = img[i];
            acc = in_valid && in_ready;
            tick();
            cyc++;
            chk("load_status", 32'(m_status), acc ? 32'd1 : 32'd0);
            if (acc) begin
                chk("load_addr", 32'(m_addr), 32'(i));
                i++;
            end
        end
        in_valid = 1'b0;
        chk("load_beats", 32'(i), 32'(n));
    endtask

    task automatic check_log(input int base);
        chk("wr_count", 32'(wr_cnt - base), 32'(LL));
        for (int k = 0; k < LL; k++) begin
            chk("wr_addr", 32'(log_addr[(base + k) & 255]), 32'(k));
            chk("wr_data", 32'(log_data[(base + k) & 255]), 32'(img[k]));
        end
    endtask

    task automatic read_frame(input int mode, input bit poke_start);
        int got = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [7:0] held = 8'h00;
        first_acc = -1;
        last_acc = -1;
        while (got < RL && cyc < 100) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            start = poke_start && (cyc < 3);
            if (stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(held));
            end
            if (out_valid && out_ready) begin
                chk("rd_byte", 32'(out_data), 32'(exp_out[got]));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                got++;
            end
            if (poke_start) chk("busy_in_read", 32'(busy), 32'd1);
            stall = out_valid && !out_ready;
            held = out_data;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        chk("rd_count", 32'(got), 32'(RL));
        chk("done_pulse", 32'(done), 32'd1);
        tick();
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        m_end_process = 1'b0;
        repeat (2) tick();

        chk("rst_status", 32'(m_status), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: no stalls anywhere
        for (int k = 0; k < 16; k++) img[k] = 8'(k);
        for (int k = 0; k < 4; k++) exp_out[k] = 8'(8 + k);
        wr_base = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_in_ready", 32'(in_ready), 32'd1);
        chk("f1_busy", 32'(busy), 32'd1);
        load_frame(1, LL);
        chk("f1_last_status", 32'(m_status), 32'd1);
        chk("f1_last_addr", 32'(m_addr), 32'd15);
        chk("f1_last_data", 32'(m_data), 32'h0F);
        chk("f1_ready_drop", 32'(in_ready), 32'd0);
        tick();
        chk("f1_run_status", 32'(m_status), 32'd2);
        check_log(wr_base);
        repeat (2) tick();
        chk("f1_run_hold", 32'(m_status), 32'd2);
        m_end_process = 1'b1;
        tick();
        m_end_process = 1'b0;
        read_frame(0, 1'b0);
        chk("f1_first_out", 32'(first_acc), 32'd2);
        chk("f1_last_out", 32'(last_acc), 32'd5);
        chk("f1_checksum", 32'(checksum), CK_EN ? 32'h26 : 32'd0);
        tick();
        chk("f1_checksum_hold", 32'(checksum), CK_EN ? 32'h26 : 32'd0);

        // Frame 2: sparse input, toggling out_ready, start poked in RUN/READ
        wr_base = wr_cnt;
        done_base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_frame(3, LL);
        tick();
        check_log(wr_base);
        start = 1'b1;
        repeat (3) begin
            tick();
            chk("f2_run_busy", 32'(busy), 32'd1);
            chk("f2_run_status", 32'(m_status), 32'd2);
        end
        m_end_process = 1'b1;
        tick();
        m_end_process = 1'b0;
        start = 1'b0;
        read_frame(1, 1'b1);
        repeat (3) tick();
        chk("f2_stay_idle", 32'(busy), 32'd0);
        chk("f2_one_done", 32'(done_cnt - done_base), 32'd1);

        // Frame 3: reset mid-LOAD, then a full frame with checksum data
        start = 1'b1;
        tick();
        start = 1'b0;
        load_frame(1, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_status", 32'(m_status), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_checksum", 32'(checksum), 32'd0);
        img[8] = 8'hFF;
        img[9] = 8'hFF;
        img[10] = 8'h02;
        img[11] = 8'h03;
        exp_out[0] = 8'hFF;
        exp_out[1] = 8'hFF;
        exp_out[2] = 8'h02;
        exp_out[3] = 8'h03;
        wr_base = wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_frame(1, LL);
        tick();
        check_log(wr_base);
        m_end_process = 1'b1;
        tick();
        m_end_process = 1'b0;
        read_frame(0, 1'b0);
        chk("f3_first_out", 32'(first_acc), 32'd2);
        chk("f3_checksum", 32'(checksum), CK_EN ? 32'h0203 : 32'd0);

        tick();
        chk("max_outstanding_le2", 32'(max_out <= 2), 32'd1);
        chk("total_reads", 32'(rd_iss), 32'd12);
        chk("total_done", 32'(done_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ds_host_sequencer.md
Name: ds_host_sequencer

Overview:
Host-side sequencer for the down-sampling machine. It streams a raw image from a valid/ready byte interface into data memory, starts the processor, and waits for end_process. It then reads the down-sampled result back out of data memory onto a valid/ready byte stream with backpressure. It sits between the host link and the machine's status/data_in/data_addr_in/data_out ports and is the only driver of those ports.

Parameters:
ADDR_W, 16, machine data address width
DATA_W, 8, pixel/byte width
LOAD_LEN, 16384, bytes loaded per frame (128x128); range 1..2^ADDR_W
RESULT_BASE, 16'h4000, first data-memory address of the result
RESULT_LEN, 4096, result bytes read back (64x64); RESULT_BASE+RESULT_LEN <= 2^ADDR_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a frame; sampled only in IDLE
in_valid  in  1  host byte valid
in_data  in  DATA_W  host byte
in_ready  out  1  high in LOAD state only
out_valid  out  1  result byte valid
out_data  out  DATA_W  result byte
out_ready  in  1  host accepts result byte
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last result byte is accepted
m_status  out  2  machine status
m_data  out  DATA_W  machine data_in
m_addr  out  ADDR_W  machine data_addr_in
m_end_process  in  1  machine end_process
m_data_out  in  DATA_W  machine data_out; valid 1 cycle after m_addr is presented with m_status=READ
checksum  out  16  see Optional Feature

Behaviour:
- m_status encoding: IDLE=0, LOAD=1, RUN=2, READ=3.
- FSM states: S_IDLE, S_LOAD, S_RUN, S_READ, S_DONE.
- Reset: state S_IDLE, all counters 0, m_status=IDLE, m_data=0, m_addr=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, checksum=0. Reset mid-operation aborts the frame immediately and discards the skid buffer.
- S_IDLE: start=1 moves to S_LOAD next cycle. start is ignored in all other states.
- S_LOAD:
  - in_ready=1. Each accepted beat (in_valid & in_ready) registers m_data=in_data and m_addr=load_cnt, and drives m_status=LOAD for exactly that following cycle.
  - Cycles with no accepted beat drive m_status=IDLE, so no spurious memory writes occur.
  - load_cnt increments per accepted beat. When the LOAD_LEN-th beat is accepted: in_ready drops the next cycle, and that cycle still carries the last write. The FSM then enters S_RUN.
- S_RUN:
  - m_status=RUN held continuously.
  - When m_end_process is sampled 1, move to S_READ next cycle.
  - There is no timeout; end_process already high on entry counts as done.
- S_READ:
  - A read issues when rd_cnt < RESULT_LEN and skid occupancy plus in-flight reads < 2. An issue drives m_status=READ and m_addr=RESULT_BASE+rd_cnt.
  - m_data_out is captured into the skid buffer on the following cycle. Non-issue cycles drive m_status=IDLE.
  - out_valid/out_data come from the skid head. Data is held stable while out_valid & !out_ready.
  - At zero backpressure, throughput is 1 byte/cycle and first out_valid comes 2 cycles after entering S_READ.
  - When the RESULT_LEN-th byte is accepted, move to S_DONE.
- S_DONE: done=1 for one cycle, then S_IDLE.
- Width rules:
  - Counters are ADDR_W+1 bits so that LOAD_LEN=2^ADDR_W does not wrap before termination.
  - Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro DS_HOST_CHECKSUM_EN.
- Defined: checksum is a 16-bit modulo sum of every out_data byte accepted (zero-extended). It clears on entry to S_LOAD and holds after done.
- Undefined: checksum is tied to 0 and no adder is built.

Decomposition:
- Package ds_host_pkg holds:
  - the m_status encoding constants
  - the FSM state enum
  - the default LOAD_LEN, RESULT_BASE and RESULT_LEN constants
- One sub-module, ds_rd_skid, is natural: a 2-entry FIFO with push/pop, occupancy output and synchronous rst. It absorbs the 1-cycle memory read latency under backpressure.

Test Plan:
- Full frame, no stalls (LOAD_LEN=16, RESULT_LEN=4, RESULT_BASE=16'h0008): send bytes 0x00..0x0F, model memory, pulse end_process. Expect:
  - 16 LOAD writes at addresses 0..15
  - out bytes 0x08,0x09,0x0A,0x0B at 1/cycle
  - done one cycle after the 4th accept
- Host in_valid gaps (valid every 3rd cycle): m_status=LOAD only on write cycles; address sequence stays 0..15 with no repeats.
- out_ready toggling 1,0,0,1,...: no byte lost or duplicated, out_data stable during stalls, at most 2 reads outstanding.
- start asserted during S_RUN and during S_READ: ignored, busy stays 1, and there is exactly one done per frame.
- rst pulsed mid-LOAD after 5 bytes: next cycle m_status=IDLE, in_ready=0, busy=0. A new frame then restarts writes at address 0.
- DS_HOST_CHECKSUM_EN defined: results 0xFF,0xFF,0x02,0x03 give checksum=0x0203. Undefined: checksum stays 0.
